// File: rtl/xintf_regfile_slave_if.sv
// DSP XINTF pin bundle: address, strobes and split data bus.
// The master drives the pins; the slave returns read data and the pad enable.
interface xintf_regfile_slave_if #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 16
);
  logic [ADDR_W-1:0] address;
  logic              nCS;
  logic              nRD;
  logic              nWR;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;
  logic              data_oe;

  modport master (
    output address, nCS, nRD, nWR, data_in,
    input  data_out, data_oe
  );

  modport slave (
    input  address, nCS, nRD, nWR, data_in,
    output data_out, data_oe
  );
endinterface

// File: rtl/xintf_regfile_slave.sv
// DSP XINTF slave: NUM_REGS R/W words plus one read-only status word, with
// synchronised strobes, commit-on-release writes and fabric wr/rd pulses.
//
// state     | meaning
// ST_IDLE   | no write in progress
// ST_WACT   | synced nWR low, capturing address/data every cycle
// ST_COMMIT | nWR released, apply captured write for one cycle
module xintf_regfile_slave #(
  parameter int                 ADDR_W      = 15,
  parameter int                 DATA_W      = 16,
  parameter logic [ADDR_W-1:0]  BASE_ADDR   = 15'h3FF0,
  parameter int                 NUM_REGS    = 16,
  parameter int                 SYNC_STAGES = 2,
  parameter logic [DATA_W-1:0]  RESET_VAL   = '0
) (
  input  logic                         clk,
  input  logic                         nRST,
  xintf_regfile_slave_if.slave         bus,
  output logic [NUM_REGS*DATA_W-1:0]   regs_flat,
  input  logic [DATA_W-1:0]            status_in,
  output logic                         wr_strobe,
  output logic [5:0]                   wr_index,
  output logic                         rd_strobe,
  output logic [5:0]                   rd_index,
  output logic                         err_flag,
  input  logic                         err_clear
);

  typedef enum logic [1:0] {ST_IDLE, ST_WACT, ST_COMMIT} wstate_e;

  localparam logic [ADDR_W:0] STATUS_OFF = (ADDR_W+1)'(NUM_REGS);

  function automatic logic [ADDR_W:0] win_off(input logic [ADDR_W-1:0] a);
    return {1'b0, a} - {1'b0, BASE_ADDR};
  endfunction

  function automatic logic win_hit(input logic [ADDR_W:0] off);
    return !off[ADDR_W] && (off <= STATUS_OFF);
  endfunction

  wstate_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0]  cs_sync_q, rd_sync_q, wr_sync_q;
  logic                    s_cs, s_rd, s_wr;
  logic                    srd_prev_q;
  logic                    conflict, conflict_q, conflict_d;

  logic [DATA_W-1:0]       regs_q [NUM_REGS];
  logic [DATA_W-1:0]       regs_d [NUM_REGS];

  logic [ADDR_W-1:0]       waddr_q, waddr_d;
  logic [DATA_W-1:0]       wdata_q, wdata_d;
  logic                    cap_valid_q, cap_valid_d;
  logic [ADDR_W:0]         w_off;
  logic                    wr_strobe_q, wr_strobe_d;
  logic [5:0]              wr_index_q, wr_index_d;
  logic                    wr_err;

  logic                    rd_act_q, rd_act_d;
  logic [ADDR_W-1:0]       rd_addr_q, rd_addr_d;
  logic [ADDR_W:0]         r_off;
  logic                    rd_strobe_q, rd_strobe_d;
  logic [5:0]              rd_index_q, rd_index_d;
  logic                    rd_err;

  logic [ADDR_W:0]         pin_off;
  logic                    pin_hit;
  logic [DATA_W-1:0]       rd_word;
  logic [DATA_W-1:0]       data_out_q;
  logic                    err_q, err_d;

  assign s_cs     = cs_sync_q[SYNC_STAGES-1];
  assign s_rd     = rd_sync_q[SYNC_STAGES-1];
  assign s_wr     = wr_sync_q[SYNC_STAGES-1];
  assign conflict = !s_cs && !s_rd && !s_wr;

  // Write FSM: next state, capture and commit.
  always_comb begin
    state_d     = state_q;
    waddr_d     = waddr_q;
    wdata_d     = wdata_q;
    cap_valid_d = cap_valid_q;
    regs_d      = regs_q;
    wr_strobe_d = 1'b0;
    wr_index_d  = wr_index_q;
    wr_err      = 1'b0;
    w_off       = win_off(waddr_q);
    case (state_q)
      ST_IDLE: begin
        if (!s_cs && !s_wr && s_rd && !conflict_q) state_d = ST_WACT;
      end
      ST_WACT: begin
        if (conflict) begin
          state_d     = ST_IDLE;
          cap_valid_d = 1'b0;
        end else if (s_wr) begin
          state_d = ST_COMMIT;
        end else if (s_cs) begin
          state_d     = ST_IDLE;
          cap_valid_d = 1'b0;
        end else begin
          waddr_d     = bus.address;
          wdata_d     = bus.data_in;
          cap_valid_d = 1'b1;
        end
      end
      ST_COMMIT: begin
        state_d     = ST_IDLE;
        cap_valid_d = 1'b0;
        if (cap_valid_q) begin
          if (!win_hit(w_off)) begin
            wr_err = 1'b1;
          end else if (w_off < STATUS_OFF) begin
            for (int i = 0; i < NUM_REGS; i++) begin
              if (w_off == (ADDR_W+1)'(i)) regs_d[i] = wdata_q;
            end
            wr_strobe_d = 1'b1;
            wr_index_d  = w_off[5:0];
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Read completion tracking; a read seen overlapping a write never completes.
  always_comb begin
    rd_act_d    = rd_act_q;
    rd_addr_d   = rd_addr_q;
    rd_strobe_d = 1'b0;
    rd_index_d  = rd_index_q;
    rd_err      = 1'b0;
    r_off       = win_off(rd_addr_q);
    conflict_d  = conflict_q;
    if (conflict) conflict_d = 1'b1;
    else if (s_cs || (s_rd && s_wr)) conflict_d = 1'b0;

    if (conflict) begin
      rd_act_d = 1'b0;
    end else if (!s_cs && !s_rd) begin
      if (!conflict_q) begin
        rd_act_d  = 1'b1;
        rd_addr_d = bus.address;
      end
    end else if (s_rd && !srd_prev_q && rd_act_q) begin
      rd_act_d = 1'b0;
      if (win_hit(r_off)) begin
        rd_strobe_d = 1'b1;
        rd_index_d  = r_off[5:0];
      end else begin
        rd_err = 1'b1;
      end
    end else if (s_cs) begin
      rd_act_d = 1'b0;
    end
  end

  always_comb begin
    pin_off = win_off(bus.address);
    pin_hit = win_hit(pin_off);
    rd_word = '0;
    if (pin_hit) begin
      if (pin_off == STATUS_OFF) begin
        rd_word = status_in;
      end else begin
        for (int i = 0; i < NUM_REGS; i++) begin
          if (pin_off == (ADDR_W+1)'(i)) rd_word = regs_q[i];
        end
      end
    end
  end

  always_comb begin
    err_d = err_q;
    if (wr_err || rd_err || conflict) err_d = 1'b1;
    else if (err_clear)               err_d = 1'b0;
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state_q     <= ST_IDLE;
      cs_sync_q   <= '1;
      rd_sync_q   <= '1;
      wr_sync_q   <= '1;
      srd_prev_q  <= 1'b1;
      conflict_q  <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= RESET_VAL;
      waddr_q     <= '0;
      wdata_q     <= '0;
      cap_valid_q <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_index_q  <= '0;
      rd_act_q    <= 1'b0;
      rd_addr_q   <= '0;
      rd_strobe_q <= 1'b0;
      rd_index_q  <= '0;
      data_out_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], bus.nCS};
      rd_sync_q   <= {rd_sync_q[SYNC_STAGES-2:0], bus.nRD};
      wr_sync_q   <= {wr_sync_q[SYNC_STAGES-2:0], bus.nWR};
      srd_prev_q  <= s_rd;
      conflict_q  <= conflict_d;
      regs_q      <= regs_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
      cap_valid_q <= cap_valid_d;
      wr_strobe_q <= wr_strobe_d;
      wr_index_q  <= wr_index_d;
      rd_act_q    <= rd_act_d;
      rd_addr_q   <= rd_addr_d;
      rd_strobe_q <= rd_strobe_d;
      rd_index_q  <= rd_index_d;
      data_out_q  <= rd_word;
      err_q       <= err_d;
    end
  end

  // Pad enable follows the pins directly so the DSP sees data without sync lag.
  assign bus.data_oe  = !bus.nCS && !bus.nRD && bus.nWR && pin_hit;
  assign bus.data_out = data_out_q;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign regs_flat[g*DATA_W +: DATA_W] = regs_q[g];
  end

  assign wr_strobe = wr_strobe_q;
  assign wr_index  = wr_index_q;
  assign rd_strobe = rd_strobe_q;
  assign rd_index  = rd_index_q;
  assign err_flag  = err_q;

endmodule

// File: tb/tb_xintf_regfile_slave.sv
// Directed bench for xintf_regfile_slave: DSP-style write/read cycles driven
// on negedges, outputs sampled on negedges against hand-computed values.
module tb_xintf_regfile_slave;

  logic         clk = 1'b0;
  logic         nRST;
  logic [255:0] regs_flat;
  logic [15:0]  status_in;
  logic         wr_strobe, rd_strobe, err_flag, err_clear;
  logic [5:0]   wr_index, rd_index;

  int n_checks = 0;
  int n_fail   = 0;
  int wr_cnt   = 0;
  int rd_cnt   = 0;

  xintf_regfile_slave_if #(.ADDR_W(15), .DATA_W(16)) bus ();

  xintf_regfile_slave dut (
    .clk       (clk),
    .nRST      (nRST),
    .bus       (bus),
    .regs_flat (regs_flat),
    .status_in (status_in),
    .wr_strobe (wr_strobe),
    .wr_index  (wr_index),
    .rd_strobe (rd_strobe),
    .rd_index  (rd_index),
    .err_flag  (err_flag),
    .err_clear (err_clear)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (wr_strobe === 1'b1) wr_cnt++;
    if (rd_strobe === 1'b1) rd_cnt++;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] reg_word(input int i);
    return regs_flat[i*16 +: 16];
  endfunction

  task automatic dsp_write(input logic [14:0] addr, input logic [15:0] data);
    @(negedge clk);
    bus.address = addr;
    bus.data_in = data;
    bus.nCS     = 1'b0;
    @(negedge clk);
    bus.nWR = 1'b0;
    repeat (5) @(negedge clk);
    bus.nWR = 1'b1;
    @(negedge clk);
    bus.nCS = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic dsp_read(input logic [14:0] addr, output logic [15:0] dat, output logic oe);
    @(negedge clk);
    bus.address = addr;
    bus.nCS     = 1'b0;
    @(negedge clk);
    bus.nRD = 1'b0;
    repeat (4) @(negedge clk);
    dat = bus.data_out;
    oe  = bus.data_oe;
    bus.nRD = 1'b1;
    @(negedge clk);
    bus.nCS = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  initial begin
    logic [15:0] dat;
    logic        oe;
    int          w0, r0;
    logic [15:0] exp_reg [16];

    nRST        = 1'b0;
    bus.address = '0;
    bus.data_in = '0;
    bus.nCS     = 1'b1;
    bus.nRD     = 1'b1;
    bus.nWR     = 1'b1;
    status_in   = 16'h0000;
    err_clear   = 1'b0;
    repeat (3) @(negedge clk);

    check_eq("rst_regs_flat_lo", regs_flat[31:0], 32'h0);
    check_eq("rst_err", err_flag, 1'b0);
    check_eq("rst_wr_strobe", wr_strobe, 1'b0);
    check_eq("rst_data_out", bus.data_out, 16'h0);
    check_eq("rst_data_oe", bus.data_oe, 1'b0);
    nRST = 1'b1;
    repeat (2) @(negedge clk);

    // Fill every register with index+1.
    w0 = wr_cnt;
    for (int i = 0; i < 16; i++) begin
      dsp_write(15'h3FF0 + 15'(i), 16'(i + 1));
      check_eq($sformatf("wr_index_%0d", i), wr_index, 32'(i));
      exp_reg[i] = 16'(i + 1);
    end
    check_eq("wr_strobe_count", wr_cnt - w0, 16);
    for (int i = 0; i < 16; i++)
      check_eq($sformatf("reg_after_fill_%0d", i), reg_word(i), exp_reg[i]);
    check_eq("err_after_fill", err_flag, 1'b0);

    r0 = rd_cnt;
    for (int i = 0; i < 16; i++) begin
      dsp_read(15'h3FF0 + 15'(i), dat, oe);
      check_eq($sformatf("rd_data_%0d", i), dat, 16'(i + 1));
      check_eq($sformatf("rd_oe_%0d", i), oe, 1'b1);
    end
    check_eq("rd_strobe_count", rd_cnt - r0, 16);
    check_eq("rd_index_last", rd_index, 6'd15);

    status_in = 16'hA5A5;
    dsp_read(15'h4000, dat, oe);
    check_eq("status_data", dat, 16'hA5A5);
    check_eq("status_oe", oe, 1'b1);
    check_eq("status_rd_index", rd_index, 6'd16);
    check_eq("status_rd_count", rd_cnt - r0, 17);

    // Out-of-window writes: below base (borrow) and one past the status word.
    w0 = wr_cnt;
    dsp_write(15'h3FEF, 16'h1234);
    check_eq("err_below_base", err_flag, 1'b1);
    err_clear = 1'b1;
    @(negedge clk);
    err_clear = 1'b0;
    @(negedge clk);
    check_eq("err_cleared_1", err_flag, 1'b0);
    dsp_write(15'h4001, 16'h1234);
    check_eq("err_above_status", err_flag, 1'b1);
    check_eq("miss_no_strobe", wr_cnt - w0, 0);
    for (int i = 0; i < 16; i++)
      check_eq($sformatf("reg_after_miss_%0d", i), reg_word(i), exp_reg[i]);
    dsp_read(15'h4001, dat, oe);
    check_eq("miss_read_oe", oe, 1'b0);
    check_eq("miss_read_data", dat, 16'h0);
    err_clear = 1'b1;
    @(negedge clk);
    err_clear = 1'b0;
    @(negedge clk);
    check_eq("err_cleared_2", err_flag, 1'b0);

    w0 = wr_cnt;
    dsp_write(15'h4000, 16'hBEEF);
    check_eq("status_wr_no_strobe", wr_cnt - w0, 0);
    check_eq("status_wr_no_err", err_flag, 1'b0);
    check_eq("status_wr_reg15", reg_word(15), 16'h0010);

    // nRD and nWR low together.
    w0 = wr_cnt;
    r0 = rd_cnt;
    @(negedge clk);
    bus.address = 15'h3FF3;
    bus.data_in = 16'h9999;
    bus.nCS     = 1'b0;
    @(negedge clk);
    bus.nRD = 1'b0;
    bus.nWR = 1'b0;
    repeat (5) @(negedge clk);
    check_eq("conflict_oe", bus.data_oe, 1'b0);
    bus.nRD = 1'b1;
    bus.nWR = 1'b1;
    @(negedge clk);
    bus.nCS = 1'b1;
    repeat (6) @(negedge clk);
    check_eq("conflict_reg3", reg_word(3), 16'h0004);
    check_eq("conflict_err", err_flag, 1'b1);
    check_eq("conflict_no_wr", wr_cnt - w0, 0);
    check_eq("conflict_no_rd", rd_cnt - r0, 0);
    err_clear = 1'b1;
    @(negedge clk);
    err_clear = 1'b0;

    // Back-to-back writes with nCS held low.
    w0 = wr_cnt;
    @(negedge clk);
    bus.nCS     = 1'b0;
    bus.address = 15'h3FF0;
    bus.data_in = 16'h0A0B;
    @(negedge clk);
    bus.nWR = 1'b0;
    repeat (5) @(negedge clk);
    bus.nWR = 1'b1;
    repeat (5) @(negedge clk);
    bus.address = 15'h3FF1;
    bus.data_in = 16'h0C0D;
    @(negedge clk);
    bus.nWR = 1'b0;
    repeat (5) @(negedge clk);
    bus.nWR = 1'b1;
    @(negedge clk);
    bus.nCS = 1'b1;
    repeat (6) @(negedge clk);
    check_eq("b2b_reg0", reg_word(0), 16'h0A0B);
    check_eq("b2b_reg1", reg_word(1), 16'h0C0D);
    check_eq("b2b_strobes", wr_cnt - w0, 2);

    // Write strobe entirely inside reset.
    w0 = wr_cnt;
    @(negedge clk);
    bus.address = 15'h3FF5;
    bus.data_in = 16'h7777;
    bus.nCS     = 1'b0;
    nRST        = 1'b0;
    @(negedge clk);
    bus.nWR = 1'b0;
    repeat (5) @(negedge clk);
    bus.nWR = 1'b1;
    @(negedge clk);
    bus.nCS = 1'b1;
    @(negedge clk);
    nRST = 1'b1;
    repeat (6) @(negedge clk);
    check_eq("rst_mid_reg5", reg_word(5), 16'h0000);
    check_eq("rst_mid_reg0", reg_word(0), 16'h0000);
    check_eq("rst_mid_no_strobe", wr_cnt - w0, 0);
    check_eq("rst_mid_wr_index", wr_index, 6'd0);
    check_eq("rst_mid_err", err_flag, 1'b0);
    dsp_write(15'h3FF5, 16'h0055);
    check_eq("post_rst_reg5", reg_word(5), 16'h0055);
    check_eq("post_rst_wr_index", wr_index, 6'd5);
    check_eq("post_rst_strobe", wr_cnt - w0, 1);
    check_eq("post_rst_reg4", reg_word(4), 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
